// File: rtl/demux_pkg.sv
// Shared types and helpers for the buffered 1-to-4 demultiplexer.
package demux_pkg;

    typedef logic [1:0] chan_t;

    localparam int NCHAN = 4;

    // Round-robin successor; 3 wraps back to 0.
    function automatic chan_t next_ptr(input chan_t p);
        return (p == chan_t'(NCHAN - 1)) ? chan_t'(0) : chan_t'(p + chan_t'(1));
    endfunction

endpackage

// File: rtl/demux4_buf_if.sv
// Stream-in / four-channel-out handshake bundle for demux4_buf.
interface demux4_buf_if #(
    parameter int W = 4
);
    logic [W-1:0] d;
    logic [1:0]   s;
    logic         auto;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic [3:0]   y_valid;
    logic [3:0]   y_ready;
    logic [1:0]   ptr;

    modport master (
        output d, s, auto, in_valid, y_ready,
        input  in_ready, y0, y1, y2, y3, y_valid, ptr
    );

    modport slave (
        input  d, s, auto, in_valid, y_ready,
        output in_ready, y0, y1, y2, y3, y_valid, ptr
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// A write in the same cycle as a drain reloads the slot without a bubble.
module demux_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);
    logic [W-1:0] r_data;
    logic         r_valid;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (wr) begin
            r_data  <= din;
            r_valid <= 1'b1;
        end else if (rd) begin
            r_valid <= 1'b0;
        end
    end

    assign dout  = r_data;
    assign valid = r_valid;
    // Cannot take a word only when occupied and not being drained this cycle.
    assign full  = r_valid && !rd;

endmodule

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 demux: routes the input stream to a slot chosen by s or
// by a round-robin pointer that advances only on accepted auto-mode words.
module demux4_buf
    import demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic       clk,
    input  logic       reset,
    demux4_buf_if.slave bus
);
    chan_t            r_ptr;
    chan_t            w_dst;
    logic             w_accept;
    logic [NCHAN-1:0] w_wr;
    logic [NCHAN-1:0] w_full;
    logic [NCHAN-1:0] w_valid;
    logic [W-1:0]     w_dout [NCHAN];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_dst = bus.s;
        if (bus.auto) begin
            w_dst = r_ptr;
        end
    end

    // in_ready depends on y_ready (via full) but never on in_valid.
    assign bus.in_ready = !w_full[w_dst];
    assign w_accept     = bus.in_valid && bus.in_ready;

    for (genvar k = 0; k < NCHAN; k++) begin : g_slot
        assign w_wr[k] = w_accept && (w_dst == chan_t'(k));

        demux_slot #(.W(W)) u_slot (
            .clk   (clk),
            .reset (reset),
            .wr    (w_wr[k]),
            .din   (bus.d),
            .rd    (bus.y_ready[k]),
            .dout  (w_dout[k]),
            .valid (w_valid[k]),
            .full  (w_full[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept && bus.auto) begin
            r_ptr <= next_ptr(r_ptr);
        end
    end

    assign bus.y0      = w_dout[0];
    assign bus.y1      = w_dout[1];
    assign bus.y2      = w_dout[2];
    assign bus.y3      = w_dout[3];
    assign bus.y_valid = w_valid;
    assign bus.ptr     = r_ptr;

endmodule

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf: directed vectors with literal checks,
// plus a per-cycle comparison against a behavioural channel model.
module tb_demux4_buf;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    bit   cmp_en;

    // Behavioural model: four slots, each either empty or holding a word.
    int   m_data  [4];
    bit   m_valid [4];
    int   m_ptr;

    demux4_buf_if #(.W(W)) bif ();

    demux4_buf #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_dst();
        return bif.auto ? m_ptr : int'(bif.s);
    endfunction

    function automatic bit model_ready();
        int t;
        t = model_dst();
        return !m_valid[t] || bif.y_ready[t];
    endfunction

    always @(posedge clk) begin
        int  t;
        bit  take;
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                m_data[k]  = 0;
                m_valid[k] = 0;
            end
            m_ptr = 0;
        end else begin
            t    = model_dst();
            take = bif.in_valid && model_ready();
            for (int k = 0; k < 4; k++)
                if (bif.y_ready[k]) m_valid[k] = 0;
            if (take) begin
                m_data[t]  = int'(bif.d);
                m_valid[t] = 1;
                if (bif.auto) m_ptr = (m_ptr + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_y_valid", 32'(bif.y_valid),
                  {28'd0, m_valid[3], m_valid[2], m_valid[1], m_valid[0]});
            check("cmp_y0", 32'(bif.y0), 32'(m_data[0]));
            check("cmp_y1", 32'(bif.y1), 32'(m_data[1]));
            check("cmp_y2", 32'(bif.y2), 32'(m_data[2]));
            check("cmp_y3", 32'(bif.y3), 32'(m_data[3]));
            check("cmp_ptr", 32'(bif.ptr), 32'(m_ptr));
            check("cmp_in_ready", 32'(bif.in_ready), 32'(model_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic au, input logic [1:0] sel,
                         input logic [W-1:0] data, input logic [3:0] yr);
        bif.in_valid = iv;
        bif.auto     = au;
        bif.s        = sel;
        bif.d        = data;
        bif.y_ready  = yr;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cmp_en   = 0;
        for (int k = 0; k < 4; k++) begin
            m_data[k]  = 0;
            m_valid[k] = 0;
        end
        m_ptr = 0;

        // Reset held two cycles with a word offered.
        reset = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 4'hF, 4'b0000);
        step();
        cmp_en = 1;
        step();
        check("rst_y_valid", 32'(bif.y_valid), 32'h0);
        check("rst_ptr", 32'(bif.ptr), 32'h0);
        check("rst_y0", 32'(bif.y0), 32'h0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000);
        #1;
        check("rst_in_ready", 32'(bif.in_ready), 32'h1);
        step();

        // Manual routing A,B,C,D to channels 0..3 with all consumers ready.
        drive(1'b1, 1'b0, 2'd0, 4'hA, 4'b1111);
        step();
        check("man_valid_first", 32'(bif.y_valid), 32'h1);
        drive(1'b1, 1'b0, 2'd1, 4'hB, 4'b1111);
        step();
        check("man_valid_second", 32'(bif.y_valid), 32'h2);
        drive(1'b1, 1'b0, 2'd2, 4'hC, 4'b1111);
        step();
        drive(1'b1, 1'b0, 2'd3, 4'hD, 4'b1111);
        step();
        check("man_y0", 32'(bif.y0), 32'hA);
        check("man_y1", 32'(bif.y1), 32'hB);
        check("man_y2", 32'(bif.y2), 32'hC);
        check("man_y3", 32'(bif.y3), 32'hD);
        check("man_ptr", 32'(bif.ptr), 32'h0);

        // Round-robin over six words: ptr 1,2,3,0,1,2.
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, 2'd0, 4'(i), 4'b1111);
            step();
            check("rr_ptr", 32'(bif.ptr), 32'(i % 4));
            check("rr_valid", 32'(bif.y_valid), 32'(1 << ((i - 1) % 4)));
        end
        check("rr_y0", 32'(bif.y0), 32'h5);
        check("rr_y1", 32'(bif.y1), 32'h6);
        check("rr_y2", 32'(bif.y2), 32'h3);
        check("rr_y3", 32'(bif.y3), 32'h4);

        // Drain, then backpressure on channel 2.
        drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);
        step();
        drive(1'b1, 1'b0, 2'd2, 4'h5, 4'b0000);
        step();
        check("bp_y2_first", 32'(bif.y2), 32'h5);
        check("bp_valid_first", 32'(bif.y_valid), 32'h4);
        drive(1'b1, 1'b0, 2'd2, 4'h6, 4'b0000);
        #1;
        check("bp_stall_ready", 32'(bif.in_ready), 32'h0);
        step();
        check("bp_y2_held", 32'(bif.y2), 32'h5);
        drive(1'b1, 1'b0, 2'd1, 4'h7, 4'b0000);
        #1;
        check("bp_other_ready", 32'(bif.in_ready), 32'h1);
        step();
        check("bp_y1", 32'(bif.y1), 32'h7);
        check("bp_valid_two", 32'(bif.y_valid), 32'h6);
        drive(1'b1, 1'b0, 2'd2, 4'h6, 4'b0100);
        #1;
        check("bp_reload_ready", 32'(bif.in_ready), 32'h1);
        step();
        check("bp_reload_y2", 32'(bif.y2), 32'h6);
        check("bp_reload_valid", 32'(bif.y_valid), 32'h6);

        // Auto toggle with channel 3 stalled; ptr is 2 coming in.
        drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);
        step();
        drive(1'b1, 1'b1, 2'd0, 4'hC, 4'b1111);
        step();
        check("at_ptr3", 32'(bif.ptr), 32'h3);
        drive(1'b1, 1'b0, 2'd3, 4'h8, 4'b0000);
        step();
        check("at_ptr_hold_manual", 32'(bif.ptr), 32'h3);
        drive(1'b1, 1'b1, 2'd0, 4'hE, 4'b0000);
        #1;
        check("at_stall_ready", 32'(bif.in_ready), 32'h0);
        step();
        check("at_stall_ptr", 32'(bif.ptr), 32'h3);
        check("at_stall_y3", 32'(bif.y3), 32'h8);
        drive(1'b1, 1'b0, 2'd0, 4'h9, 4'b0000);
        #1;
        check("at_manual_ready", 32'(bif.in_ready), 32'h1);
        step();
        check("at_y0", 32'(bif.y0), 32'h9);
        check("at_ptr_kept", 32'(bif.ptr), 32'h3);

        // Fill the last slot, then reset mid-operation with a word offered.
        drive(1'b1, 1'b0, 2'd1, 4'h1, 4'b0000);
        step();
        check("mr_all_full", 32'(bif.y_valid), 32'hF);
        reset = 1'b1;
        drive(1'b1, 1'b0, 2'd1, 4'hF, 4'b0000);
        step();
        check("mr_valid", 32'(bif.y_valid), 32'h0);
        check("mr_ptr", 32'(bif.ptr), 32'h0);
        check("mr_y1", 32'(bif.y1), 32'h0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000);
        step();
        step();
        cmp_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
